if_stage: RTL

Instruction-fetch stage of the MIPS pipeline. It holds the program counter and the instruction memory, which the debug unit loads word by word. It drives the IF/ID pipeline register that feeds the decode stage: the 26-bit jump field, immediate and register addresses all come from `o_ifid_instr`, and the PC+4 comes from `o_ifid_pc4`. It accepts redirects, which are the resolved branch/jump/JALR target from decode, and stalls from the hazard unit. All register updates are gated by the debug step enable.

---
 rtl/mips_pkg.sv | 14 +
 rtl/instruction_memory.sv | 24 ++
 rtl/if_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-stage state encoding.
package mips_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam int          PC_INC     = 4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction RAM: one synchronous write port, one asynchronous read port.
module instruction_memory #(
    parameter int BITS_SIZE      = 32,
    parameter int IMEM_ADDR_BITS = 8
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [IMEM_ADDR_BITS-1:0] wr_addr,
    input  logic [BITS_SIZE-1:0]      wr_data,
    input  logic [IMEM_ADDR_BITS-1:0] rd_addr,
    output logic [BITS_SIZE-1:0]      rd_data
);

    localparam int DEPTH = 1 << IMEM_ADDR_BITS;

    logic [BITS_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: LOAD/RUN/HALTED control, PC, instruction memory and IF/ID register.
module if_stage
    import mips_pkg::*;
#(
    parameter int BITS_SIZE      = 32,
    parameter int IMEM_ADDR_BITS = 8,
    parameter int PC_INC         = mips_pkg::PC_INC
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_step,
    input  logic                      i_start,
    input  logic                      i_stall,
    input  logic                      i_id_redirect,
    input  logic [BITS_SIZE-1:0]      i_id_target,
    input  logic                      i_imem_wr_en,
    input  logic [IMEM_ADDR_BITS-1:0] i_imem_wr_addr,
    input  logic [BITS_SIZE-1:0]      i_imem_wr_data,
    output logic [BITS_SIZE-1:0]      o_pc,
    output logic [BITS_SIZE-1:0]      o_ifid_instr,
    output logic [BITS_SIZE-1:0]      o_ifid_pc4,
    output logic                      o_halt,
    output logic                      o_loading
);

    localparam logic [BITS_SIZE-1:0] NOP_W  = BITS_SIZE'(NOP);
    localparam logic [BITS_SIZE-1:0] HALT_W = BITS_SIZE'(HALT_INSTR);
    localparam logic [BITS_SIZE-1:0] INC_W  = BITS_SIZE'(PC_INC);

    if_state_t            state, state_nxt;
    logic [BITS_SIZE-1:0] pc_nxt, instr_nxt, pc4_nxt;
    logic [BITS_SIZE-1:0] fetched, pc_plus;
    logic                 adv;

    // Program loading is only legal while the pipeline is idle in LOAD.
    instruction_memory #(
        .BITS_SIZE      (BITS_SIZE),
        .IMEM_ADDR_BITS (IMEM_ADDR_BITS)
    ) u_imem (
        .clk     (i_clk),
        .wr_en   (i_imem_wr_en && (state == ST_LOAD)),
        .wr_addr (i_imem_wr_addr),
        .wr_data (i_imem_wr_data),
        .rd_addr (o_pc[IMEM_ADDR_BITS+1:2]),
        .rd_data (fetched)
    );

    assign pc_plus = o_pc + INC_W;
    assign adv     = i_step & ~i_stall;

    always_comb begin
        state_nxt = state;
        pc_nxt    = o_pc;
        instr_nxt = o_ifid_instr;
        pc4_nxt   = o_ifid_pc4;
        case (state)
            ST_LOAD: begin
                if (i_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (adv) begin
                    if (i_id_redirect) begin
                        // Squash the wrong-path word, no delay slot.
                        pc_nxt    = {i_id_target[BITS_SIZE-1:2], 2'b00};
                        instr_nxt = NOP_W;
                        pc4_nxt   = '0;
                    end else if (fetched == HALT_W) begin
                        instr_nxt = fetched;
                        pc4_nxt   = pc_plus;
                        state_nxt = ST_HALTED;
                    end else begin
                        pc_nxt    = pc_plus;
                        instr_nxt = fetched;
                        pc4_nxt   = pc_plus;
                    end
                end
            end
            ST_HALTED: begin
                instr_nxt = NOP_W;
                pc4_nxt   = '0;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_LOAD;
            o_pc         <= '0;
            o_ifid_instr <= NOP_W;
            o_ifid_pc4   <= '0;
        end else if (i_step) begin
            state        <= state_nxt;
            o_pc         <= pc_nxt;
            o_ifid_instr <= instr_nxt;
            o_ifid_pc4   <= pc4_nxt;
        end
    end

    assign o_halt    = (state == ST_HALTED);
    assign o_loading = (state == ST_LOAD);

endmodule
